// File: rtl/dense_layer_sequencer_if.sv
// Bus bundle for the dense-layer sequencer: CPU register slave, SDRAM descriptor master
// and accelerator config master, in Avalon-MM style.
interface dense_layer_sequencer_if;
    logic [2:0]  slave_address;
    logic        slave_read;
    logic [31:0] slave_readdata;
    logic        slave_write;
    logic [31:0] slave_writedata;
    logic        slave_waitrequest;

    logic [31:0] mem_address;
    logic        mem_read;
    logic [31:0] mem_readdata;
    logic        mem_waitrequest;

    logic [2:0]  acc_address;
    logic        acc_read;
    logic        acc_write;
    logic [31:0] acc_writedata;
    logic        acc_waitrequest;

    // The sequencer's view: it initiates on mem/acc and answers the CPU.
    modport master (
        input  slave_address, slave_read, slave_write, slave_writedata,
        output slave_readdata, slave_waitrequest,
        output mem_address, mem_read,
        input  mem_readdata, mem_waitrequest,
        output acc_address, acc_read, acc_write, acc_writedata,
        input  acc_waitrequest
    );

    // The system's view: CPU bridge, SDRAM and accelerator.
    modport slave (
        output slave_address, slave_read, slave_write, slave_writedata,
        input  slave_readdata, slave_waitrequest,
        input  mem_address, mem_read,
        output mem_readdata, mem_waitrequest,
        input  acc_address, acc_read, acc_write, acc_writedata,
        output acc_waitrequest
    );
endinterface

// File: rtl/dense_layer_sequencer.sv
// Chains dense-layer runs: per layer fetches a descriptor from SDRAM, programs the
// accelerator config registers, starts it and blocks on its completion read.
module dense_layer_sequencer #(
    parameter int DESC_WORDS = 5,
    parameter int CNT_W      = 8
) (
    input logic                     clk,
    input logic                     reset,
    dense_layer_sequencer_if.master bus
);

    localparam int K_W   = (DESC_WORDS > 1) ? $clog2(DESC_WORDS) : 1;
    localparam int OFF_W = CNT_W + 3;
    localparam logic [K_W-1:0] K_LAST = K_W'(DESC_WORDS - 1);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        CFG,
        START,
        WAIT,
        NEXT,
        DONE
    } state_e;

    state_e             state_q;
    logic               busy_q;
    logic               done_q;
    logic [CNT_W-1:0]   layerIdx_q;
    logic [CNT_W-1:0]   count_q;
    logic [31:0]        base_q;
    logic [K_W-1:0]     k_q;
    logic [31:0]        desc_q [DESC_WORDS];

    logic [31:0]        memAddr_q;
    logic               memRead_q;
    logic [2:0]         accAddr_q;
    logic               accRead_q;
    logic               accWrite_q;
    logic [31:0]        accData_q;

    logic [K_W-1:0]     kNext_d;
    logic [CNT_W-1:0]   layerNext_d;
    logic               cpuStart;
    logic               memDone;
    logic               accDone;
    logic [31:0]        rdData;

    function automatic logic [31:0] descAddr(input logic [31:0]      b,
                                             input logic [CNT_W-1:0] idx,
                                             input logic [K_W-1:0]   k);
        logic [OFF_W-1:0] off;
        off = OFF_W'(DESC_WORDS) * OFF_W'(idx);
        return b + 32'(off) + 32'(k);
    endfunction

    assign kNext_d     = k_q + K_W'(1);
    assign layerNext_d = layerIdx_q + CNT_W'(1);
    assign cpuStart    = bus.slave_write && (bus.slave_address == 3'd0);
    assign memDone     = memRead_q && !bus.mem_waitrequest;
    assign accDone     = (accWrite_q || accRead_q) && !bus.acc_waitrequest;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= IDLE;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            layerIdx_q <= '0;
            count_q    <= '0;
            base_q     <= '0;
            k_q        <= '0;
            memAddr_q  <= '0;
            memRead_q  <= 1'b0;
            accAddr_q  <= '0;
            accRead_q  <= 1'b0;
            accWrite_q <= 1'b0;
            accData_q  <= '0;
            for (int i = 0; i < DESC_WORDS; i++) begin
                desc_q[i] <= '0;
            end
        end else begin
            if (!busy_q && bus.slave_write) begin
                if (bus.slave_address == 3'd1) base_q  <= bus.slave_writedata;
                if (bus.slave_address == 3'd2) count_q <= bus.slave_writedata[CNT_W-1:0];
            end

            case (state_q)
                // DONE lasts one cycle but, being not busy, still accepts a restart.
                IDLE, DONE: begin
                    if (cpuStart) begin
                        layerIdx_q <= '0;
                        k_q        <= '0;
                        if (count_q == '0) begin
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            state_q <= DONE;
                        end else begin
                            busy_q    <= 1'b1;
                            done_q    <= 1'b0;
                            memRead_q <= 1'b1;
                            memAddr_q <= descAddr(base_q, '0, '0);
                            state_q   <= FETCH;
                        end
                    end else if (state_q == DONE) begin
                        state_q <= IDLE;
                    end
                end
                FETCH: begin
                    if (memDone) begin
                        desc_q[k_q] <= bus.mem_readdata;
                        if (k_q == K_LAST) begin
                            memRead_q  <= 1'b0;
                            k_q        <= '0;
                            accWrite_q <= 1'b1;
                            accAddr_q  <= 3'd1;
                            accData_q  <= (k_q == '0) ? bus.mem_readdata : desc_q[0];
                            state_q    <= CFG;
                        end else begin
                            k_q       <= kNext_d;
                            memAddr_q <= descAddr(base_q, layerIdx_q, kNext_d);
                        end
                    end
                end
                CFG: begin
                    if (accDone) begin
                        if (k_q == K_LAST) begin
                            accAddr_q <= 3'd0;
                            accData_q <= '0;
                            state_q   <= START;
                        end else begin
                            k_q       <= kNext_d;
                            accAddr_q <= 3'(kNext_d) + 3'd1;
                            accData_q <= desc_q[kNext_d];
                        end
                    end
                end
                START: begin
                    if (accDone) begin
                        accWrite_q <= 1'b0;
                        accRead_q  <= 1'b1;
                        state_q    <= WAIT;
                    end
                end
                // The accelerator stalls this read until the layer finishes.
                WAIT: begin
                    if (accDone) begin
                        accRead_q <= 1'b0;
                        state_q   <= NEXT;
                    end
                end
                NEXT: begin
                    layerIdx_q <= layerNext_d;
                    if (layerNext_d == count_q) begin
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end else begin
                        k_q       <= '0;
                        memRead_q <= 1'b1;
                        memAddr_q <= descAddr(base_q, layerNext_d, '0);
                        state_q   <= FETCH;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    always_comb begin
        rdData = '0;
        if (bus.slave_read) begin
            case (bus.slave_address)
                3'd0:    rdData = {30'b0, done_q, busy_q};
                3'd1:    rdData = base_q;
                3'd2:    rdData = 32'(count_q);
                3'd3:    rdData = 32'(layerIdx_q);
                default: rdData = '0;
            endcase
        end
    end

    assign bus.slave_readdata    = rdData;
    assign bus.slave_waitrequest = 1'b0;
    assign bus.mem_address       = memAddr_q;
    assign bus.mem_read          = memRead_q;
    assign bus.acc_address       = accAddr_q;
    assign bus.acc_read          = accRead_q;
    assign bus.acc_write         = accWrite_q;
    assign bus.acc_writedata     = accData_q;

endmodule

// File: tb/tb_dense_layer_sequencer.sv
// Bench for dense_layer_sequencer: SDRAM and accelerator responders with programmable
// stalls, transaction logs, and a per-run expected transaction list built from the rules.
module tb_dense_layer_sequencer;

    localparam int DW = 5;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    dense_layer_sequencer_if bus ();

    dense_layer_sequencer #(.DESC_WORDS(DW), .CNT_W(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.master)
    );

    int total = 0;
    int bad   = 0;

    logic [31:0] memArr [logic [31:0]];
    logic [31:0] memLog [$];
    logic [31:0] expMem [$];
    logic [35:0] accLog [$];
    logic [35:0] expAcc [$];

    int memStall   = 0;
    int accWrStall = 0;
    int accRdStall = 0;
    int stabErr    = 0;
    int strobeErr  = 0;

    // Memory and accelerator responders; decisions made on the falling edge take effect
    // at the next rising edge, where a low waitrequest completes the transfer.
    initial begin : responder
        int memCnt;
        int accCnt;
        int limit;
        logic memHeld;
        logic accHeld;
        logic [31:0] memPrev;
        logic [36:0] accPrev;
        memCnt = 0; accCnt = 0; memHeld = 1'b0; accHeld = 1'b0;
        memPrev = '0; accPrev = '0;
        bus.mem_waitrequest = 1'b0;
        bus.mem_readdata    = '0;
        bus.acc_waitrequest = 1'b0;
        forever begin
            @(negedge clk);
            if (reset === 1'b1) begin
                if (memHeld && (bus.mem_read !== 1'b1 || bus.mem_address !== memPrev)) stabErr++;
                if (accHeld && ({bus.acc_read, bus.acc_write, bus.acc_address, bus.acc_writedata} !== accPrev)) stabErr++;
                if ((int'(bus.mem_read) + int'(bus.acc_read) + int'(bus.acc_write)) > 1) strobeErr++;
            end
            if (bus.mem_read === 1'b1) begin
                if (memCnt < memStall) begin
                    bus.mem_waitrequest = 1'b1;
                    memCnt++;
                end else begin
                    bus.mem_waitrequest = 1'b0;
                    memCnt = 0;
                    bus.mem_readdata = memArr.exists(bus.mem_address) ? memArr[bus.mem_address] : ~bus.mem_address;
                    if (reset === 1'b1) memLog.push_back(bus.mem_address);
                end
            end else begin
                bus.mem_waitrequest = 1'b0;
                memCnt = 0;
            end
            if (bus.acc_write === 1'b1 || bus.acc_read === 1'b1) begin
                limit = (bus.acc_read === 1'b1) ? accRdStall : accWrStall;
                if (accCnt < limit) begin
                    bus.acc_waitrequest = 1'b1;
                    accCnt++;
                end else begin
                    bus.acc_waitrequest = 1'b0;
                    accCnt = 0;
                    if (reset === 1'b1)
                        accLog.push_back({bus.acc_read, bus.acc_address,
                                          (bus.acc_read === 1'b1) ? 32'd0 : bus.acc_writedata});
                end
            end else begin
                bus.acc_waitrequest = 1'b0;
                accCnt = 0;
            end
            memHeld = (reset === 1'b1) && (bus.mem_read === 1'b1) && bus.mem_waitrequest;
            accHeld = (reset === 1'b1) && (bus.acc_read === 1'b1 || bus.acc_write === 1'b1) && bus.acc_waitrequest;
            memPrev = bus.mem_address;
            accPrev = {bus.acc_read, bus.acc_write, bus.acc_address, bus.acc_writedata};
        end
    end

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cpuWrite(input logic [2:0] a, input logic [31:0] d);
        @(negedge clk);
        bus.slave_address   = a;
        bus.slave_writedata = d;
        bus.slave_write     = 1'b1;
        @(negedge clk);
        bus.slave_write     = 1'b0;
    endtask

    task automatic cpuRead(input logic [2:0] a, output logic [31:0] d);
        @(negedge clk);
        bus.slave_address = a;
        bus.slave_read    = 1'b1;
        #1;
        d = bus.slave_readdata;
        bus.slave_read    = 1'b0;
    endtask

    task automatic fillDesc(input logic [31:0] base, input int count);
        for (int i = 0; i < DW * count; i++) memArr[base + 32'(i)] = $urandom;
    endtask

    // Expected traffic: per layer, DW sequential word reads, config writes 1..DW with the
    // fetched words, a start write, then one completion read.
    task automatic buildModel(input logic [31:0] base, input int count);
        logic [31:0] a;
        expMem.delete();
        expAcc.delete();
        for (int l = 0; l < count; l++) begin
            for (int k = 0; k < DW; k++) begin
                a = base + 32'(DW * l + k);
                expMem.push_back(a);
            end
            for (int k = 0; k < DW; k++) begin
                a = base + 32'(DW * l + k);
                expAcc.push_back({1'b0, 3'(k + 1), memArr[a]});
            end
            expAcc.push_back({1'b0, 3'd0, 32'd0});
            expAcc.push_back({1'b1, 3'd0, 32'd0});
        end
    endtask

    task automatic applyStimulus(input logic [31:0] base, input int count);
        cpuWrite(3'd1, base);
        cpuWrite(3'd2, 32'(count));
        buildModel(base, count);
        memLog.delete();
        accLog.delete();
        cpuWrite(3'd0, 32'd0);
    endtask

    task automatic waitDone(input string tag);
        logic [31:0] d;
        int n;
        n = 0;
        do begin
            cpuRead(3'd0, d);
            n++;
        end while (d[1] !== 1'b1 && n < 3000);
        checkOutput({tag, " rd0 done"}, 64'(d), 64'd2);
    endtask

    task automatic compareRun(input string tag);
        int n;
        checkOutput({tag, " mem count"}, 64'(memLog.size()), 64'(expMem.size()));
        n = (memLog.size() < expMem.size()) ? memLog.size() : expMem.size();
        for (int i = 0; i < n; i++)
            checkOutput($sformatf("%s mem[%0d]", tag, i), 64'(memLog[i]), 64'(expMem[i]));
        checkOutput({tag, " acc count"}, 64'(accLog.size()), 64'(expAcc.size()));
        n = (accLog.size() < expAcc.size()) ? accLog.size() : expAcc.size();
        for (int i = 0; i < n; i++)
            checkOutput($sformatf("%s acc[%0d]", tag, i), 64'(accLog[i]), 64'(expAcc[i]));
    endtask

    initial begin : main
        logic [31:0] d;
        logic [31:0] base;
        int cnt;
        int n;
        bus.slave_address   = '0;
        bus.slave_read      = 1'b0;
        bus.slave_write     = 1'b0;
        bus.slave_writedata = '0;
        reset = 1'b0;
        repeat (3) @(negedge clk);

        $display("[TB] reset state");
        cpuRead(3'd0, d); checkOutput("reset rd0", 64'(d), 64'd0);
        cpuRead(3'd1, d); checkOutput("reset rd1", 64'(d), 64'd0);
        cpuRead(3'd2, d); checkOutput("reset rd2", 64'(d), 64'd0);
        cpuRead(3'd3, d); checkOutput("reset rd3", 64'(d), 64'd0);
        checkOutput("reset strobes", 64'({bus.mem_read, bus.acc_read, bus.acc_write}), 64'd0);
        cpuRead(3'd5, d); checkOutput("reset rd5", 64'(d), 64'd0);
        @(negedge clk);
        reset = 1'b1;

        $display("[TB] single layer, no stalls");
        memArr[32'd40] = 32'd15; memArr[32'd41] = 32'd1; memArr[32'd42] = 32'd10;
        memArr[32'd43] = 32'd32; memArr[32'd44] = 32'd3;
        applyStimulus(32'd40, 1);
        waitDone("t1");
        compareRun("t1");
        checkOutput("t1 first cfg", 64'(accLog.size() > 0 ? accLog[0] : 36'h0), 64'({1'b0, 3'd1, 32'd15}));
        cpuRead(3'd3, d); checkOutput("t1 rd3", 64'(d), 64'd1);
        cpuRead(3'd1, d); checkOutput("t1 rd1", 64'(d), 64'd40);

        $display("[TB] back-to-back restart");
        applyStimulus(32'd40, 1);
        cpuRead(3'd0, d); checkOutput("t6 rd0 busy", 64'(d), 64'd1);
        cpuRead(3'd3, d); checkOutput("t6 rd3", 64'(d), 64'd0);
        waitDone("t6");
        compareRun("t6");

        $display("[TB] two layers with stalls");
        memStall = 3; accRdStall = 20;
        fillDesc(32'd100, 2);
        applyStimulus(32'd100, 2);
        waitDone("t2");
        compareRun("t2");
        checkOutput("t2 second fetch", 64'(memLog.size() > 5 ? memLog[5] : 32'h0), 64'd105);
        cpuRead(3'd3, d); checkOutput("t2 rd3", 64'(d), 64'd2);
        memStall = 0; accRdStall = 0;

        $display("[TB] zero layer count");
        applyStimulus(32'd200, 0);
        n = 0;
        do begin
            cpuRead(3'd0, d);
            n++;
        end while (d !== 32'd2 && n < 3);
        checkOutput("t3 rd0", 64'(d), 64'd2);
        repeat (5) @(negedge clk);
        compareRun("t3");

        $display("[TB] writes while busy");
        base = $urandom;
        fillDesc(base, 2);
        applyStimulus(base, 2);
        cpuWrite(3'd2, 32'd9);
        cpuWrite(3'd0, 32'd0);
        waitDone("t4");
        repeat (10) @(negedge clk);
        compareRun("t4");
        cpuRead(3'd2, d); checkOutput("t4 rd2", 64'(d), 64'd2);
        cpuRead(3'd3, d); checkOutput("t4 rd3", 64'(d), 64'd2);
        cpuRead(3'd1, d); checkOutput("t4 rd1", 64'(d), 64'(base));

        $display("[TB] reset during stalled config write");
        accWrStall = 1000;
        fillDesc(32'd7, 1);
        applyStimulus(32'd7, 1);
        n = 0;
        while (bus.acc_write !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        checkOutput("t5 acc_write seen", 64'(bus.acc_write), 64'd1);
        reset = 1'b0;
        @(negedge clk);
        checkOutput("t5 strobes", 64'({bus.mem_read, bus.acc_read, bus.acc_write}), 64'd0);
        cpuRead(3'd0, d); checkOutput("t5 rd0", 64'(d), 64'd0);
        cpuRead(3'd1, d); checkOutput("t5 rd1", 64'(d), 64'd0);
        cpuRead(3'd2, d); checkOutput("t5 rd2", 64'(d), 64'd0);
        reset = 1'b1;
        accWrStall = 0;

        $display("[TB] randomized runs");
        for (int r = 0; r < 4; r++) begin
            base = (r == 0) ? 32'hFFFF_FFFE : $urandom;
            cnt  = $urandom_range(1, 3);
            memStall   = $urandom_range(0, 2);
            accWrStall = $urandom_range(0, 2);
            accRdStall = $urandom_range(0, 5);
            fillDesc(base, cnt);
            applyStimulus(base, cnt);
            waitDone($sformatf("rand%0d", r));
            compareRun($sformatf("rand%0d", r));
            cpuRead(3'd3, d); checkOutput($sformatf("rand%0d rd3", r), 64'(d), 64'(cnt));
        end

        checkOutput("stable under stall", 64'(stabErr), 64'd0);
        checkOutput("single strobe", 64'(strobeErr), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
